addsub_result_checker: RTL
==========================

// Module: addsub_result_checker
// PURPOSE
//  Sequential consumer end of the Adder_subtractor interface: receives operand/result tuples
//  (a, b, sel, sum, c_out) over a valid/ready handshake and recomputes the expected result.
//  Counts passes and fails and captures the first mismatching tuple.
//  Sits beside any Adder_subtractor instance as an on-chip self-check and scoreboard.
// PARAMETERS
//  bit_len   8    operand/result width; must match the checked Adder_subtractor
//  cnt_len   16   width of pass/fail counters
// PORTS
//  clk       in   1        single clock, all logic on rising edge
//  rst       in   1        synchronous, active-high reset
//  start     in   1        pulse: clear counters/capture, enter RUN
//  stop      in   1        pulse: end checking session, enter DONE
//  in_valid  in   1        tuple on a/b/sel/sum/c_out is valid
//  in_ready  out  1        checker accepts tuple this cycle
//  a, b      in   bit_len  operands presented to the adder/subtractor
//  sel       in   1        0 = add, 1 = subtract
//  sum       in   bit_len  result from the adder/subtractor
//  c_out     in   1        carry out from the adder/subtractor
//  pass_cnt  out  cnt_len  matching tuples checked
//  fail_cnt  out  cnt_len  mismatching tuples checked
//  err_flag  out  1        sticky: at least one mismatch this session
//  err_tuple out  3*bit_len+2  first mismatch {a, b, sel, sum, c_out}
//  busy      out  1        state is RUN
//  done      out  1        state is DONE
// BEHAVIOUR
//  - Reset: state IDLE; in_ready, pass_cnt, fail_cnt, err_flag, err_tuple, busy and done all 0.
//  - Reset mid-session: abandons the in-flight tuple; nothing is counted.
//  - FSM: IDLE --start--> RUN; RUN --stop--> DONE; DONE --start--> RUN.
//    start in IDLE/DONE clears counters, err_flag and err_tuple.
//    start in RUN is ignored. stop outside RUN is ignored.
//  - in_ready = 1 only in RUN. A tuple is accepted when in_valid & in_ready.
//  - Expected value, computed at bit_len+1 bits:
//    sel=0: {c_exp,s_exp} = a + b
//    sel=1: {c_exp,s_exp} = a + ~b + 1 (c_exp=1 means no borrow, i.e. a >= b unsigned)
//  - Pipeline: an accepted tuple is registered in stage 1. The comparison
//    ({c_out,sum} vs {c_exp,s_exp}) and the counter update happen one cycle later.
//    Result latency is 1 cycle after acceptance. Full throughput: 1 tuple per cycle.
//  - Match: pass_cnt += 1. Mismatch: fail_cnt += 1 and err_flag <= 1.
//    err_tuple loads only while err_flag is 0, so it holds the first failure.
//  - Counters saturate at all-ones and never wrap.
//  - stop together with an accepted tuple: that tuple is still checked (drains from stage 1).
//    The FSM enters DONE in the same cycle the stage-1 result is counted; done rises then.
//    In DONE, all results stay stable until the next start.
//  - start and stop together in IDLE/DONE: start wins. In RUN: stop wins.
// CONFIGURATION
//  - Macro ADDSUB_CHK_HALT_ON_ERR_EN.
//  - Defined: the first counted mismatch forces RUN -> DONE in the cycle it is counted.
//    in_ready drops in that same cycle. A tuple accepted in the same cycle is discarded, not counted.
//  - Undefined: mismatches are counted and checking continues until stop.
// TESTING
//  1. Reset, start; tuple a=10, b=6, sel=0, sum=16, c_out=0 -> one cycle later pass_cnt=1, fail_cnt=0.
//  2. Subtraction with borrow: a=5, b=10, sel=1, sum=251, c_out=0 -> pass_cnt increments.
//     Then a=15, b=6, sel=1, sum=9, c_out=1 -> pass_cnt=2.
//  3. Inject sum=17 for a=8, b=5, sel=0 -> fail_cnt=1, err_flag=1, err_tuple={8,5,0,17,0}.
//     A later bad tuple leaves err_tuple unchanged.
//  4. Back-to-back valid tuples for 300 cycles, stop asserted alongside the last accept
//     -> pass_cnt=300, done=1 exactly one cycle later, in_ready=0.
//  5. Force 2^cnt_len+3 mismatches (cnt_len=4 build) -> fail_cnt holds 15, no wrap.
//     Then rst mid-stream -> all outputs 0 on the next cycle.
//  6. With ADDSUB_CHK_HALT_ON_ERR_EN defined: bad tuple then 2 good tuples
//     -> fail_cnt=1, pass_cnt=0, done=1, the good tuples are not counted.

Source files
------------

// File: rtl/addsub_result_checker.sv
// On-chip scoreboard for an Adder_subtractor: recomputes {c_out,sum} for each tuple and counts passes/fails.
// Optional: ADDSUB_CHK_HALT_ON_ERR_EN stops the session on the first counted mismatch.
module addsub_result_checker #(
    parameter int bit_len = 8,
    parameter int cnt_len = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [bit_len-1:0]     a,
    input  logic [bit_len-1:0]     b,
    input  logic                   sel,
    input  logic [bit_len-1:0]     sum,
    input  logic                   c_out,
    output logic [cnt_len-1:0]     pass_cnt,
    output logic [cnt_len-1:0]     fail_cnt,
    output logic                   err_flag,
    output logic [3*bit_len+1:0]   err_tuple,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nx;
    logic                 stop_pend;
    logic                 s1_v;
    logic [bit_len-1:0]   s1_a, s1_b, s1_sum;
    logic                 s1_sel, s1_cout;
    logic [bit_len:0]     exp_res;
    logic                 mismatch;
    logic                 halt;
    logic                 accept;

    assign in_ready = (state == RUN) && !stop_pend;
    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        exp_res = '0;
        if (s1_sel)
            exp_res = {1'b0, s1_a} + {1'b0, ~s1_b} + (bit_len+1)'(1);
        else
            exp_res = {1'b0, s1_a} + {1'b0, s1_b};
    end

    assign mismatch = s1_v && ({s1_cout, s1_sum} != exp_res);

`ifdef ADDSUB_CHK_HALT_ON_ERR_EN
    assign halt = mismatch && (state == RUN);
`else
    assign halt = 1'b0;
`endif

    // A stop is held pending for one cycle so the tuple in stage 1 is counted
    // on the same edge that the FSM enters DONE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (stop_pend || halt) state_nx = DONE;
            DONE:    if (start) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            stop_pend <= 1'b0;
            s1_v      <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_sel    <= 1'b0;
            s1_sum    <= '0;
            s1_cout   <= 1'b0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            err_flag  <= 1'b0;
            err_tuple <= '0;
        end else begin
            state     <= state_nx;
            stop_pend <= (state == RUN) && (state_nx == RUN) && (stop || stop_pend);
            // A tuple taken on the halting edge is dropped.
            s1_v      <= accept && !halt;
            if (accept) begin
                s1_a    <= a;
                s1_b    <= b;
                s1_sel  <= sel;
                s1_sum  <= sum;
                s1_cout <= c_out;
            end

            if (start && (state != RUN)) begin
                pass_cnt  <= '0;
                fail_cnt  <= '0;
                err_flag  <= 1'b0;
                err_tuple <= '0;
            end else if (s1_v) begin
                if (!mismatch) begin
                    if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
                end else begin
                    if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                    err_flag <= 1'b1;
                    if (!err_flag) err_tuple <= {s1_a, s1_b, s1_sel, s1_sum, s1_cout};
                end
            end
        end
    end

endmodule
